// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback/hazard bundle for the scoreboarded register file
interface regfile_sb_if #(
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int AW     = 5,
  parameter int DW     = 32
);
  logic [NREAD*AW-1:0]  ra;
  logic [NREAD*DW-1:0]  rd;
  logic [NREAD-1:0]     busy;
  logic [NWRITE-1:0]    we;
  logic [NWRITE*AW-1:0] wa;
  logic [NWRITE*DW-1:0] wd;
  logic                 issue_valid;
  logic [AW-1:0]        issue_dst;
  logic                 issue_ready;
  logic                 flush;
  modport master(output ra, we, wa, wd, issue_valid, issue_dst, flush, input rd, busy, issue_ready);
  modport slave(input ra, we, wa, wd, issue_valid, issue_dst, flush, output rd, busy, issue_ready);
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write bypass and per-register pending-write scoreboard
module regfile_sb #(
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int CW       = 2,
  parameter bit ZERO_REG = 1
) (
  input logic clk,
  input logic resetn,
  regfile_sb_if.slave bus
);
  localparam int NR = 2**AW;
  localparam int SW = CW + $clog2(NWRITE) + 1;
  logic [DW-1:0] regs [NR];
  logic [CW-1:0] cnt [NR];
  logic [SW-1:0] dec [NR];
  logic [SW-1:0] nxt [NR];
  logic inc;
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      dec[r] = '0;
      for (int j = 0; j < NWRITE; j++) dec[r] += SW'(bus.we[j] && bus.wa[j*AW +: AW] == AW'(r));
    end
  end
  assign bus.issue_ready = (ZERO_REG && bus.issue_dst == '0) ||
                           !(cnt[bus.issue_dst] == '1 && dec[bus.issue_dst] == '0);
  assign inc = bus.issue_valid && bus.issue_ready && !bus.flush && !(ZERO_REG && bus.issue_dst == '0);
  // Sum is formed wide enough to hold cnt+1 so the clamp at zero sees the true difference
  always_comb begin
    logic [SW-1:0] s;
    s = '0;
    for (int r = 0; r < NR; r++) begin
      s = SW'(cnt[r]) + SW'(inc && bus.issue_dst == AW'(r));
      nxt[r] = s > dec[r] ? s - dec[r] : '0;
    end
  end
  always_comb begin
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    a = '0;
    v = '0;
    bus.rd = '0;
    bus.busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      a = bus.ra[i*AW +: AW];
      v = regs[a];
      for (int j = 0; j < NWRITE; j++) v = (bus.we[j] && bus.wa[j*AW +: AW] == a) ? bus.wd[j*DW +: DW] : v;
      bus.rd[i*DW +: DW] = (ZERO_REG && a == '0) ? '0 : v;
      bus.busy[i] = !(ZERO_REG && a == '0) && SW'(cnt[a]) > dec[a];
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NR; r++) begin
        regs[r] <= '0;
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NR; r++) cnt[r] <= bus.flush ? '0 : CW'(nxt[r]);
      for (int j = 0; j < NWRITE; j++)
        if (bus.we[j] && !(ZERO_REG && bus.wa[j*AW +: AW] == '0)) regs[bus.wa[j*AW +: AW]] <= bus.wd[j*DW +: DW];
    end
  end
endmodule
